// File: rtl/handshake_pkg.sv
`default_nettype none
// ============================================================================
// Module   : handshake_pkg
// Purpose  : Shared types and width helpers for the handshake FIFO bridge.
// Revision : 1.0 - initial release
// ============================================================================
package handshake_pkg;

    typedef enum logic {
        MODE_REG    = 1'b0,
        MODE_BYPASS = 1'b1
    } bypass_mode_e;

    // Pointer width; a depth of one still needs a one-bit address.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/handshake_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : handshake_fifo_mem
// Purpose  : DEPTH x DATA_W storage, one synchronous write port, async read.
// Revision : 1.0 - initial release
// ============================================================================
module handshake_fifo_mem
    import handshake_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [ptr_w(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic [ptr_w(DEPTH)-1:0]   rd_addr,
    output logic [DATA_W-1:0]         rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/handshake_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module   : handshake_fifo_bridge
// Purpose  : Valid/ready FIFO bridge with registered upstream ready, optional
//            empty fall-through, occupancy output and synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module handshake_fifo_bridge
    import handshake_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int BYPASS = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      valid_pre_i,
    input  logic [DATA_W-1:0]         data_i,
    output logic                      ready_pre_o,
    output logic                      valid_post_o,
    output logic [DATA_W-1:0]         data_o,
    input  logic                      ready_post_i,
    input  logic                      flush_i,
    output logic [cnt_w(DEPTH)-1:0]   count_o
);

    localparam int           PW   = ptr_w(DEPTH);
    localparam int           CW   = cnt_w(DEPTH);
    localparam bypass_mode_e MODE = (BYPASS != 0) ? MODE_BYPASS : MODE_REG;

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     next_count;
    logic              ready_reg;
    logic              next_ready;
    logic              empty;
    logic              fall_through;
    logic              push;
    logic              pop;
    logic              through;
    logic              wr_en;
    logic              rd_adv;
    logic [DATA_W-1:0] rd_data;

    assign empty = (count == '0);

    generate
        if (MODE == MODE_BYPASS) begin : g_bypass
            assign fall_through = empty;
        end else begin : g_registered
            assign fall_through = 1'b0;
        end
    endgenerate

    assign ready_pre_o  = ready_reg;
    assign valid_post_o = ~empty | (fall_through & valid_pre_i & ~flush_i);
    assign data_o       = fall_through ? data_i : rd_data;
    assign count_o      = count;

    assign push    = valid_pre_i & ready_reg;
    assign pop     = valid_post_o & ready_post_i;
    // A word that enters and leaves an empty bypass FIFO never touches storage.
    assign through = fall_through & push & pop;
    assign wr_en   = push & ~through & ~flush_i;
    assign rd_adv  = pop & ~through & ~flush_i;

    always_comb begin
        next_count = count;
        if (flush_i) begin
            next_count = '0;
        end else if (wr_en && !rd_adv) begin
            next_count = count + CW'(1);
        end else if (!wr_en && rd_adv) begin
            next_count = count - CW'(1);
        end
        next_ready = (next_count < CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ready_reg <= 1'b0;
        end else begin
            count     <= next_count;
            ready_reg <= next_ready;
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (rd_adv) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
        end
    end

    handshake_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (data_i),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_handshake_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_handshake_fifo_bridge
// Purpose  : Self-checking bench over four depth/bypass configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_handshake_fifo_bridge;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       valid_pre;
    logic [7:0] din;
    logic       ready_post;
    logic       flush;

    logic       rp0, rp1, rp2, rp3;
    logic       vp0, vp1, vp2, vp3;
    logic [7:0] do0, do1, do2, do3;
    logic [2:0] cn0, cn1;
    logic [3:0] cn2, cn3;

    logic       rp_s;
    logic       vp_s;
    logic [7:0] dout_s;
    logic [3:0] cnt_s;

    int sel = 0;
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    handshake_fifo_bridge #(.DATA_W(8), .DEPTH(4), .BYPASS(0)) u_d4_reg (
        .clk(clk), .reset_n(reset_n), .valid_pre_i(valid_pre), .data_i(din),
        .ready_pre_o(rp0), .valid_post_o(vp0), .data_o(do0),
        .ready_post_i(ready_post), .flush_i(flush), .count_o(cn0));
    handshake_fifo_bridge #(.DATA_W(8), .DEPTH(4), .BYPASS(1)) u_d4_byp (
        .clk(clk), .reset_n(reset_n), .valid_pre_i(valid_pre), .data_i(din),
        .ready_pre_o(rp1), .valid_post_o(vp1), .data_o(do1),
        .ready_post_i(ready_post), .flush_i(flush), .count_o(cn1));
    handshake_fifo_bridge #(.DATA_W(8), .DEPTH(8), .BYPASS(0)) u_d8_reg (
        .clk(clk), .reset_n(reset_n), .valid_pre_i(valid_pre), .data_i(din),
        .ready_pre_o(rp2), .valid_post_o(vp2), .data_o(do2),
        .ready_post_i(ready_post), .flush_i(flush), .count_o(cn2));
    handshake_fifo_bridge #(.DATA_W(8), .DEPTH(8), .BYPASS(1)) u_d8_byp (
        .clk(clk), .reset_n(reset_n), .valid_pre_i(valid_pre), .data_i(din),
        .ready_pre_o(rp3), .valid_post_o(vp3), .data_o(do3),
        .ready_post_i(ready_post), .flush_i(flush), .count_o(cn3));

    always_comb begin
        rp_s = rp0; vp_s = vp0; dout_s = do0; cnt_s = {1'b0, cn0};
        case (sel)
            1: begin rp_s = rp1; vp_s = vp1; dout_s = do1; cnt_s = {1'b0, cn1}; end
            2: begin rp_s = rp2; vp_s = vp2; dout_s = do2; cnt_s = cn2; end
            3: begin rp_s = rp3; vp_s = vp3; dout_s = do3; cnt_s = cn3; end
            default: ;
        endcase
    end

    task automatic apply_reset();
        reset_n = 1'b0; valid_pre = 1'b0; din = 8'h00; ready_post = 1'b0; flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; valid_pre = 1'b0; ready_post = 1'b0; flush = 1'b0;
        #1;
        for (int s = 0; s < 4; s++) begin
            sel = s; #1;
            total++; if (rp_s !== 1'b0) $display("FAIL reset_ready cfg%0d: got %b want 0", s, rp_s); else passed++;
            total++; if (vp_s !== 1'b0) $display("FAIL reset_valid cfg%0d: got %b want 0", s, vp_s); else passed++;
            total++; if (cnt_s !== 4'd0) $display("FAIL reset_count cfg%0d: got %0d want 0", s, cnt_s); else passed++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk); #1;
        for (int s = 0; s < 4; s++) begin
            sel = s; #1;
            total++; if (rp_s !== 1'b1) $display("FAIL reset_release_ready cfg%0d: got %b want 1", s, rp_s); else passed++;
        end
    endtask

    // Random or alternating traffic against a queue model and an in-order counter.
    task automatic test_stream(input int cfg, input int nwords, input bit alt);
        int         depth;
        bit         byp;
        logic [7:0] q[$];
        logic [7:0] tx;
        logic [7:0] rx;
        int         sent;
        int         got;
        int         cyc;
        bit         mready;
        int         sz;
        bit         ev;
        logic [7:0] ed;
        bit         push;
        bit         pop;
        bit         ph;
        int         errs;
        depth = (cfg >= 2) ? 8 : 4;
        byp = (cfg % 2) == 1;
        tx = 8'h00; rx = 8'h00; sent = 0; got = 0; cyc = 0; mready = 1'b0; ph = 1'b0; errs = 0;
        sel = cfg;
        apply_reset();
        valid_pre = alt ? 1'b1 : ($urandom_range(0, 99) < 70);
        din = tx;
        while (got < nwords && cyc < 4000) begin
            ready_post = alt ? ph : ($urandom_range(0, 99) < 60);
            ph = ~ph;
            flush = 1'b0;
            #1;
            sz = q.size();
            ev = (sz != 0) || (byp && valid_pre);
            ed = (sz != 0) ? q[0] : din;
            total++; if (vp_s !== ev) begin errs++; $display("FAIL stream_valid cfg%0d cyc%0d: got %b want %b", cfg, cyc, vp_s, ev); end else passed++;
            if (ev) begin
                total++; if (dout_s !== ed) begin errs++; $display("FAIL stream_data cfg%0d cyc%0d: got %0h want %0h", cfg, cyc, dout_s, ed); end else passed++;
            end
            total++; if (rp_s !== mready) begin errs++; $display("FAIL stream_ready cfg%0d cyc%0d: got %b want %b", cfg, cyc, rp_s, mready); end else passed++;
            total++; if (cnt_s !== 4'(sz)) begin errs++; $display("FAIL stream_count cfg%0d cyc%0d: got %0d want %0d", cfg, cyc, cnt_s, sz); end else passed++;
            total++; if (int'(cnt_s) > depth) begin errs++; $display("FAIL stream_overfill cfg%0d: got %0d want <=%0d", cfg, cnt_s, depth); end else passed++;
            push = valid_pre && mready;
            pop = ev && ready_post;
            if (pop) begin
                total++; if (dout_s !== rx) begin errs++; $display("FAIL stream_order cfg%0d: got %0h want %0h", cfg, dout_s, rx); end else passed++;
                rx++; got++;
            end
            if (!(byp && sz == 0 && push && pop)) begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back(din);
            end
            mready = q.size() < depth;
            if (push) begin tx++; sent++; end
            @(negedge clk);
            cyc++;
            if (push || !valid_pre) begin
                valid_pre = (sent < nwords) && (alt ? 1'b1 : ($urandom_range(0, 99) < 70));
                din = tx;
            end
            if (errs > 20) break;
        end
        valid_pre = 1'b0;
        ready_post = 1'b0;
        total++; if (got !== nwords) $display("FAIL stream_words cfg%0d: got %0d want %0d", cfg, got, nwords); else passed++;
    endtask

    task automatic test_full();
        sel = 0;
        apply_reset();
        valid_pre = 1'b1; ready_post = 1'b0; din = 8'h40;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (rp_s !== 1'b1) $display("FAIL full_ready_before push%0d: got %b want 1", i, rp_s); else passed++;
            @(negedge clk);
            din = din + 8'h01;
        end
        #1;
        total++; if (rp_s !== 1'b0) $display("FAIL full_ready_drop: got %b want 0", rp_s); else passed++;
        total++; if (cnt_s !== 4'd4) $display("FAIL full_count: got %0d want 4", cnt_s); else passed++;
        ready_post = 1'b1;
        #1;
        total++; if (dout_s !== 8'h40) $display("FAIL full_head: got %0h want 40", dout_s); else passed++;
        @(negedge clk);
        ready_post = 1'b0;
        #1;
        total++; if (rp_s !== 1'b1) $display("FAIL full_ready_rise: got %b want 1", rp_s); else passed++;
        total++; if (cnt_s !== 4'd3) $display("FAIL full_after_pop: got %0d want 3", cnt_s); else passed++;
        @(negedge clk);
        valid_pre = 1'b0;
        #1;
        total++; if (cnt_s !== 4'd4) $display("FAIL full_refill_count: got %0d want 4", cnt_s); else passed++;
        total++; if (rp_s !== 1'b0) $display("FAIL full_refill_ready: got %b want 0", rp_s); else passed++;
    endtask

    task automatic test_bypass();
        sel = 1;
        apply_reset();
        @(negedge clk);
        valid_pre = 1'b1; din = 8'h2A; ready_post = 1'b1;
        #1;
        total++; if (vp_s !== 1'b1) $display("FAIL bypass_valid: got %b want 1", vp_s); else passed++;
        total++; if (dout_s !== 8'h2A) $display("FAIL bypass_data: got %0h want 2a", dout_s); else passed++;
        @(negedge clk);
        valid_pre = 1'b0;
        #1;
        total++; if (cnt_s !== 4'd0) $display("FAIL bypass_count: got %0d want 0", cnt_s); else passed++;
        total++; if (vp_s !== 1'b0) $display("FAIL bypass_idle: got %b want 0", vp_s); else passed++;
        sel = 0;
        apply_reset();
        @(negedge clk);
        valid_pre = 1'b1; din = 8'h2A; ready_post = 1'b1;
        #1;
        total++; if (vp_s !== 1'b0) $display("FAIL reg_valid_early: got %b want 0", vp_s); else passed++;
        @(negedge clk);
        valid_pre = 1'b0;
        #1;
        total++; if (vp_s !== 1'b1) $display("FAIL reg_valid_late: got %b want 1", vp_s); else passed++;
        total++; if (dout_s !== 8'h2A) $display("FAIL reg_data_late: got %0h want 2a", dout_s); else passed++;
        total++; if (cnt_s !== 4'd1) $display("FAIL reg_count: got %0d want 1", cnt_s); else passed++;
        @(negedge clk);
        #1;
        total++; if (cnt_s !== 4'd0) $display("FAIL reg_drain: got %0d want 0", cnt_s); else passed++;
        ready_post = 1'b0;
    endtask

    task automatic test_flush();
        sel = 0;
        apply_reset();
        @(negedge clk);
        ready_post = 1'b0; valid_pre = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = 8'h10 + 8'(i);
            @(negedge clk);
        end
        flush = 1'b1; din = 8'h13;
        #1;
        total++; if (cnt_s !== 4'd3) $display("FAIL flush_pre_count: got %0d want 3", cnt_s); else passed++;
        @(negedge clk);
        flush = 1'b0; din = 8'h14;
        #1;
        total++; if (cnt_s !== 4'd0) $display("FAIL flush_count: got %0d want 0", cnt_s); else passed++;
        total++; if (vp_s !== 1'b0) $display("FAIL flush_valid: got %b want 0", vp_s); else passed++;
        total++; if (rp_s !== 1'b1) $display("FAIL flush_ready: got %b want 1", rp_s); else passed++;
        @(negedge clk);
        valid_pre = 1'b0;
        #1;
        total++; if (dout_s !== 8'h14) $display("FAIL flush_first_out: got %0h want 14", dout_s); else passed++;
        total++; if (cnt_s !== 4'd1) $display("FAIL flush_recount: got %0d want 1", cnt_s); else passed++;
        sel = 1;
        apply_reset();
        @(negedge clk);
        valid_pre = 1'b1; din = 8'h55; ready_post = 1'b1; flush = 1'b1;
        #1;
        total++; if (vp_s !== 1'b0) $display("FAIL flush_bypass_valid: got %b want 0", vp_s); else passed++;
        @(negedge clk);
        flush = 1'b0; valid_pre = 1'b0; ready_post = 1'b0;
        #1;
        total++; if (cnt_s !== 4'd0) $display("FAIL flush_bypass_count: got %0d want 0", cnt_s); else passed++;
    endtask

    task automatic test_async_reset();
        sel = 0;
        apply_reset();
        @(negedge clk);
        valid_pre = 1'b1; ready_post = 1'b0; din = 8'h60;
        @(negedge clk);
        din = 8'h61;
        @(negedge clk);
        valid_pre = 1'b0;
        #1;
        total++; if (cnt_s !== 4'd2) $display("FAIL areset_pre_count: got %0d want 2", cnt_s); else passed++;
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (vp_s !== 1'b0) $display("FAIL areset_valid: got %b want 0", vp_s); else passed++;
        total++; if (rp_s !== 1'b0) $display("FAIL areset_ready: got %b want 0", rp_s); else passed++;
        total++; if (cnt_s !== 4'd0) $display("FAIL areset_count: got %0d want 0", cnt_s); else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        total++; if (rp_s !== 1'b1) $display("FAIL areset_release_ready: got %b want 1", rp_s); else passed++;
        total++; if (vp_s !== 1'b0) $display("FAIL areset_stale_valid: got %b want 0", vp_s); else passed++;
        valid_pre = 1'b1; din = 8'h77;
        @(negedge clk);
        valid_pre = 1'b0; ready_post = 1'b1;
        #1;
        total++; if (dout_s !== 8'h77) $display("FAIL areset_first_word: got %0h want 77", dout_s); else passed++;
        @(negedge clk);
        ready_post = 1'b0;
        #1;
        total++; if (vp_s !== 1'b0) $display("FAIL areset_drained: got %b want 0", vp_s); else passed++;
    endtask

    initial begin
        reset_n = 1'b0; valid_pre = 1'b0; din = 8'h00; ready_post = 1'b0; flush = 1'b0;
        test_reset();
        for (int c = 0; c < 4; c++) test_stream(c, 201, 1'b0);
        test_full();
        test_bypass();
        test_flush();
        test_async_reset();
        for (int c = 0; c < 4; c++) test_stream(c, (c >= 2) ? 24 : 12, 1'b1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
